// File: rtl/ifetch_pkg.sv
// Shared fetch-stage types and constants.
// Used by ifetch_unit, fetch_fifo and the decode side.
package ifetch_pkg;

   localparam int XLEN_DEF = 32;

   // ADDI x0,x0,0: decode substitutes this for a flushed slot.
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   localparam int PC_STEP = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous circular-buffer FIFO with flush.
// Head data reads as zero while empty.
module fetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         valid,
   output logic         full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rptr;
   logic [AW-1:0] wptr;
   logic [AW:0]   cnt;
   logic          do_push;
   logic          do_pop;

   assign valid   = (cnt != '0);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign do_pop  = pop && valid;
   assign do_push = push && (!full || do_pop);
   assign rdata   = valid ? mem[rptr] : '0;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rptr <= '0;
         wptr <= '0;
         cnt  <= '0;
      end else begin
         if (do_push) begin
            wptr <= wptr + 1'b1;
         end
         if (do_pop) begin
            rptr <= rptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: cnt gates every read.
   always_ff @(posedge clk) begin
      if (!rst && !flush && do_push) begin
         mem[wptr] <= wdata;
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: PC, ROM addressing, redirect and fetch queue.
// IFETCH_PERF_EN adds perf_fetched / perf_stall counters.
module ifetch_unit
   import ifetch_pkg::*;
#(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_instr,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_stall
`endif
);

   localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);

   logic [XLEN-1:0]   pc;
   logic              full;
   logic              pop;
   logic              push;
   logic [2*XLEN-1:0] head;

   assign imem_addr = pc;
   assign pop       = out_valid && out_ready;
   // Redirect suppresses the fetch of the stale path.
   assign push      = !redirect_valid && (!full || pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (redirect_valid) begin
         pc <= redirect_pc & ALIGN;
      end else if (push) begin
         pc <= pc + XLEN'(PC_STEP);
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (2*XLEN)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (push),
      .wdata ({pc, imem_instr}),
      .pop   (pop),
      .rdata (head),
      .valid (out_valid),
      .full  (full)
   );

   assign {out_pc, out_instr} = head;

`ifdef IFETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (push) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         if (out_valid && !out_ready) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit against a queue-based model.
// Perf counters are checked when IFETCH_PERF_EN is defined.
module tb_ifetch_unit;
   import ifetch_pkg::*;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
`endif

   always #5 clk = ~clk;

   logic [31:0] rom [256];
   assign imem_instr = rom[imem_addr[9:2]];

   ifetch_unit #(
      .XLEN       (32),
      .RESET_PC   (RPC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
`ifdef IFETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_stall     (perf_stall)
`endif
   );

   typedef struct {
      bit           chk;
      bit           v;
      fetch_entry_t e;
      logic [31:0]  addr;
      logic [31:0]  pf;
      logic [31:0]  ps;
   } rec_t;

   rec_t         sb[$];
   fetch_entry_t mq[$];
   logic [31:0]  mpc;
   logic [31:0]  mpf;
   logic [31:0]  mps;
   bit           minit = 1'b0;
   int           nchk  = 0;
   int           nfail = 0;

   task automatic cmp(string nm, logic [31:0] a, logic [31:0] e);
      nchk++;
      if (a !== e) begin
         nfail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
      end
   endtask

   // One cycle: drive inputs, record what the DUT must show now,
   // then advance the model across the coming edge.
   task automatic cyc(bit r, bit rv, logic [31:0] rt, bit rdy);
      rec_t c;
      bit   p;
      bit   q;
      @(posedge clk);
      #1;
      rst            = r;
      redirect_valid = rv;
      redirect_pc    = rt;
      out_ready      = rdy;
      c.chk  = minit;
      c.v    = (mq.size() > 0);
      c.e    = c.v ? mq[0] : '0;
      c.addr = mpc;
      c.pf   = mpf;
      c.ps   = mps;
      sb.push_back(c);
      if (r) begin
         minit = 1'b1;
         mpc   = RPC;
         mpf   = '0;
         mps   = '0;
         mq.delete();
      end else begin
         if (c.v && !rdy) mps++;
         if (rv) begin
            mpc = rt & 32'hFFFF_FFFC;
            mq.delete();
         end else begin
            p = c.v && rdy;
            q = (mq.size() < DEPTH) || p;
            if (p) void'(mq.pop_front());
            if (q) begin
               mq.push_back('{pc: mpc, instr: rom[mpc[9:2]]});
               mpc = mpc + 32'd4;
               mpf++;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      rec_t c;
      if (sb.size() > 0) begin
         c = sb.pop_front();
         if (c.chk) begin
            cmp("out_valid", {31'b0, out_valid}, {31'b0, c.v});
            cmp("imem_addr", imem_addr, c.addr);
            cmp("out_pc", out_pc, c.e.pc);
            cmp("out_instr", out_instr, c.e.instr);
`ifdef IFETCH_PERF_EN
            cmp("perf_fetched", perf_fetched, c.pf);
            cmp("perf_stall", perf_stall, c.ps);
`endif
         end
      end
   end

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = $urandom;
      rom[0] = 32'h0010_0093;
      rom[1] = 32'h0030_0113;
      rom[2] = 32'h0020_81b3;

      // Streaming from reset.
      repeat (2) cyc(1, 0, '0, 1);
      repeat (6) cyc(0, 0, '0, 1);

      // Backpressure from reset, then release.
      cyc(1, 0, '0, 0);
      repeat (5) cyc(0, 0, '0, 0);
      repeat (6) cyc(0, 0, '0, 1);

      // Redirect while queue holds pcs 4 and 8.
      cyc(1, 0, '0, 0);
      repeat (3) cyc(0, 0, '0, 0);
      cyc(0, 0, '0, 1);
      cyc(0, 1, 32'h0000_0103, 0);
      repeat (2) cyc(0, 0, '0, 0);
      repeat (5) cyc(0, 0, '0, 1);

      // Wrap at the top of the address space.
      cyc(0, 1, 32'hFFFF_FFF8, 1);
      repeat (6) cyc(0, 0, '0, 1);

      // Back-to-back redirects: last one wins.
      cyc(0, 1, 32'h0000_0040, 1);
      cyc(0, 1, 32'h0000_0081, 1);
      repeat (4) cyc(0, 0, '0, 1);

      // Reset with redirect in the same cycle.
      repeat (3) cyc(0, 0, '0, 1);
      cyc(1, 1, 32'h0000_0200, 1);
      repeat (4) cyc(0, 0, '0, 1);

      // Three accepted then four stalled cycles.
      cyc(1, 0, '0, 1);
      repeat (4) cyc(0, 0, '0, 1);
      repeat (4) cyc(0, 0, '0, 0);
      repeat (3) cyc(0, 0, '0, 1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 99) < 1),
             ($urandom_range(0, 99) < 8),
             $urandom,
             ($urandom_range(0, 99) < 70));
      end

      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      cmp("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
